window_generator_fp16: RTL and testbench

Producer side of the floating-point convolution window interface. Takes a raster-order fp16 pixel stream and builds, with line buffers plus a shift-register window, the WINDOW_HEIGHT x WINDOW_WIDTH neighbourhood for every fully-interior pixel. It tags each window with its centre col/row and a valid strobe. Output feeds the window_i/col_i/row_i/valid_i inputs of the dx/dy/derivative convolution blocks directly. No backpressure: downstream accepts one window per cycle.

---
 rtl/window_gen_pkg.sv | 9 +
 rtl/line_buffer_fp.sv | 17 +
 rtl/window_generator_fp16.sv | 88 ++++++++
 tb/tb_window_generator_fp16.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/window_gen_pkg.sv
// window_gen_pkg: shared word/coordinate widths and types for the window generator
package window_gen_pkg;
    localparam int FP_EXP_WIDTH  = 5;
    localparam int FP_FRAC_WIDTH = 10;
    localparam int FP_WIDTH      = 1 + FP_EXP_WIDTH + FP_FRAC_WIDTH;
    localparam int COORD_WIDTH   = 16;
    typedef logic [FP_WIDTH-1:0]    pixel_t;
    typedef logic [COORD_WIDTH-1:0] coord_t;
endpackage

// File: rtl/line_buffer_fp.sv
// line_buffer_fp: one image line of pixels, combinational read-before-write at a single address
module line_buffer_fp #(
    parameter int DEPTH = 640,
    parameter int WIDTH = 16,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk_i,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];
    assign rdata = mem[addr];
    always_ff @(posedge clk_i)
        if (we) mem[addr] <= wdata;
endmodule

// File: rtl/window_generator_fp16.sv
// window_generator_fp16: raster fp16 stream to HxW neighbourhood windows with centre coordinates
module window_generator_fp16
    import window_gen_pkg::*;
#(
    parameter int EXP_WIDTH     = FP_EXP_WIDTH,
    parameter int FRAC_WIDTH    = FP_FRAC_WIDTH,
    parameter int FP_WIDTH_REG  = 1 + EXP_WIDTH + FRAC_WIDTH,
    parameter int WINDOW_WIDTH  = 3,
    parameter int WINDOW_HEIGHT = 3,
    parameter int IMAGE_WIDTH   = 640,
    parameter int IMAGE_HEIGHT  = 480
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [FP_WIDTH_REG-1:0] pixel_i,
    input  logic                    valid_i,
    input  logic                    sof_i,
    output logic [WINDOW_HEIGHT-1:0][WINDOW_WIDTH-1:0][FP_WIDTH_REG-1:0] window_o,
    output coord_t                  col_o,
    output coord_t                  row_o,
    output logic                    valid_o,
    output logic                    frame_done_o
);
    localparam int AW = $clog2(IMAGE_WIDTH);
    localparam coord_t COL_LAST = coord_t'(IMAGE_WIDTH - 1);
    localparam coord_t ROW_LAST = coord_t'(IMAGE_HEIGHT - 1);
    localparam coord_t COL_MIN  = coord_t'(WINDOW_WIDTH - 1);
    localparam coord_t ROW_MIN  = coord_t'(WINDOW_HEIGHT - 1);
    localparam coord_t COL_OFS  = coord_t'((WINDOW_WIDTH - 1) / 2);
    localparam coord_t ROW_OFS  = coord_t'((WINDOW_HEIGHT - 1) / 2);

    coord_t in_col, in_row, pos_col, pos_row;
    logic   col_wrap, row_wrap, emit;
    logic [WINDOW_HEIGHT-1:0][WINDOW_WIDTH-1:0][FP_WIDTH_REG-1:0] win, win_next;
    // taps[0] is the live pixel, taps[k+1] the same column k+1 lines earlier
    logic [FP_WIDTH_REG-1:0] taps [WINDOW_HEIGHT];

    assign pos_col  = sof_i ? '0 : in_col;
    assign pos_row  = sof_i ? '0 : in_row;
    assign col_wrap = pos_col == COL_LAST;
    assign row_wrap = pos_row == ROW_LAST;
    assign emit     = valid_i && pos_row >= ROW_MIN && pos_col >= COL_MIN;
    assign taps[0]  = pixel_i;

    for (genvar k = 0; k < WINDOW_HEIGHT - 1; k++) begin : g_lb
        line_buffer_fp #(.DEPTH(IMAGE_WIDTH), .WIDTH(FP_WIDTH_REG)) u_lb (
            .clk_i (clk_i),
            .we    (valid_i),
            .addr  (pos_col[AW-1:0]),
            .wdata (taps[k]),
            .rdata (taps[k+1])
        );
    end

    always_comb begin
        win_next = win;
        for (int r = 0; r < WINDOW_HEIGHT; r++) begin
            for (int c = 0; c < WINDOW_WIDTH - 1; c++) win_next[r][c] = win[r][c+1];
            win_next[r][WINDOW_WIDTH-1] = taps[WINDOW_HEIGHT-1-r];
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            in_col       <= '0;
            in_row       <= '0;
            win          <= '0;
            window_o     <= '0;
            col_o        <= '0;
            row_o        <= '0;
            valid_o      <= 1'b0;
            frame_done_o <= 1'b0;
        end else begin
            valid_o      <= emit;
            frame_done_o <= emit && col_wrap && row_wrap;
            if (valid_i) begin
                in_col <= col_wrap ? '0 : pos_col + coord_t'(1);
                in_row <= !col_wrap ? pos_row : row_wrap ? '0 : pos_row + coord_t'(1);
                win    <= win_next;
            end
            if (emit) begin
                window_o <= win_next;
                col_o    <= pos_col - COL_OFS;
                row_o    <= pos_row - ROW_OFS;
            end
        end
    end
endmodule

// File: tb/tb_window_generator_fp16.sv
// tb_window_generator_fp16: directed checks on a 5x4 image with a 3x3 window
module tb_window_generator_fp16;
    typedef logic [2:0][2:0][15:0] win_t;

    logic        clk = 1'b0, rst_n = 1'b0, valid = 1'b0, sof = 1'b0;
    logic [15:0] pixel = '0;
    win_t        window;
    logic [15:0] col, row;
    logic        vld, fd;
    int          nvec = 0, nerr = 0;
    logic [15:0] last_pix = '0;

    win_t        cap_w [$];
    logic [15:0] cap_c [$], cap_r [$], cap_p [$];
    logic        cap_fd [$];

    always #5 clk = ~clk;

    window_generator_fp16 #(.IMAGE_WIDTH(5), .IMAGE_HEIGHT(4)) dut (
        .clk_i        (clk),
        .rst_i        (rst_n),
        .pixel_i      (pixel),
        .valid_i      (valid),
        .sof_i        (sof),
        .window_o     (window),
        .col_o        (col),
        .row_o        (row),
        .valid_o      (vld),
        .frame_done_o (fd)
    );

    always @(negedge clk)
        if (rst_n && vld) begin
            cap_w.push_back(window);
            cap_c.push_back(col);
            cap_r.push_back(row);
            cap_p.push_back(last_pix);
            cap_fd.push_back(fd);
        end

    function automatic win_t exp_win(input logic [15:0] base, input int r, input int c);
        win_t w;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) w[i][j] = base + 16'((r - 1 + i) * 16 + (c - 1 + j));
        return w;
    endfunction

    task automatic clear_caps();
        cap_w.delete(); cap_c.delete(); cap_r.delete(); cap_p.delete(); cap_fd.delete();
    endtask

    task automatic send_pixel(input logic [15:0] p, input logic s);
        pixel = p; sof = s; valid = 1'b1;
        @(posedge clk);
        #1;
        last_pix = p;
        valid = 1'b0; sof = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            valid = 1'b0;
            @(posedge clk);
            #1;
            nvec++;
            if (vld !== 1'b0) begin
                nerr++;
                $display("FAIL idle_valid: valid_o=%b expected 0", vld);
            end
        end
    endtask

    task automatic send_frame(input logic [15:0] base, input int max_gap, input int npix);
        for (int k = 0; k < npix; k++) begin
            send_pixel(base + 16'((k / 5) * 16 + (k % 5)), k == 0);
            if (max_gap > 0) idle(int'($urandom_range(0, max_gap)));
        end
    endtask

    task automatic check_count(input string name, input int n);
        nvec++;
        if (cap_w.size() != n) begin
            nerr++;
            $display("FAIL %s_count: got %0d windows expected %0d", name, cap_w.size(), n);
        end
    endtask

    task automatic check_frame(input string name, input logic [15:0] base, input int first);
        int k = first;
        for (int r = 1; r <= 2; r++)
            for (int c = 1; c <= 3; c++) begin
                nvec++;
                if (k >= cap_w.size()) begin
                    nerr++;
                    $display("FAIL %s_missing: window %0d absent, expected centre (%0d,%0d)", name, k, r, c);
                end else begin
                    if (cap_w[k] !== exp_win(base, r, c)) begin
                        nerr++;
                        $display("FAIL %s_window[%0d]: got %h expected %h", name, k, cap_w[k], exp_win(base, r, c));
                    end
                    nvec++;
                    if (cap_c[k] !== 16'(c)) begin
                        nerr++;
                        $display("FAIL %s_col[%0d]: got %0d expected %0d", name, k, cap_c[k], c);
                    end
                    nvec++;
                    if (cap_r[k] !== 16'(r)) begin
                        nerr++;
                        $display("FAIL %s_row[%0d]: got %0d expected %0d", name, k, cap_r[k], r);
                    end
                    nvec++;
                    if (cap_fd[k] !== (r == 2 && c == 3)) begin
                        nerr++;
                        $display("FAIL %s_frame_done[%0d]: got %b expected %b", name, k, cap_fd[k], r == 2 && c == 3);
                    end
                end
                k++;
            end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        nvec += 5;
        if (window !== '0) begin nerr++; $display("FAIL reset_window: got %h expected 0", window); end
        if (col !== 16'd0) begin nerr++; $display("FAIL reset_col: got %0d expected 0", col); end
        if (row !== 16'd0) begin nerr++; $display("FAIL reset_row: got %0d expected 0", row); end
        if (vld !== 1'b0) begin nerr++; $display("FAIL reset_valid: got %b expected 0", vld); end
        if (fd !== 1'b0) begin nerr++; $display("FAIL reset_frame_done: got %b expected 0", fd); end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_full_frame();
        clear_caps();
        send_frame(16'h0000, 0, 20);
        idle(2);
        check_count("full", 6);
        nvec++;
        if (cap_p.size() == 0 || cap_p[0] !== 16'h0022) begin
            nerr++;
            $display("FAIL full_first_pixel: got %h expected 0022", cap_p.size() ? cap_p[0] : 16'hxxxx);
        end
        check_frame("full", 16'h0000, 0);
    endtask

    task automatic test_gaps();
        clear_caps();
        send_frame(16'h0000, 3, 20);
        idle(2);
        check_count("gaps", 6);
        check_frame("gaps", 16'h0000, 0);
    endtask

    task automatic test_back_to_back();
        clear_caps();
        send_frame(16'h0000, 0, 20);
        send_frame(16'h0100, 0, 20);
        idle(2);
        check_count("b2b", 12);
        check_frame("b2b_f1", 16'h0000, 0);
        check_frame("b2b_f2", 16'h0100, 6);
        nvec++;
        if (cap_p.size() < 7 || cap_p[6] !== 16'h0122) begin
            nerr++;
            $display("FAIL b2b_first_pixel: got %h expected 0122", cap_p.size() > 6 ? cap_p[6] : 16'hxxxx);
        end
    endtask

    task automatic test_sof_abort();
        clear_caps();
        send_frame(16'h0200, 0, 7);
        send_frame(16'h0000, 0, 20);
        idle(2);
        check_count("sof", 6);
        check_frame("sof", 16'h0000, 0);
    endtask

    task automatic test_reset_mid();
        clear_caps();
        send_frame(16'h0000, 0, 14);
        nvec++;
        if (vld !== 1'b1) begin nerr++; $display("FAIL rstmid_pre_valid: got %b expected 1", vld); end
        rst_n = 1'b0;
        #1;
        nvec += 2;
        if (vld !== 1'b0) begin nerr++; $display("FAIL rstmid_valid: got %b expected 0", vld); end
        if (fd !== 1'b0) begin nerr++; $display("FAIL rstmid_frame_done: got %b expected 0", fd); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_caps();
        send_frame(16'h0000, 0, 20);
        idle(2);
        check_count("rstmid", 6);
        check_frame("rstmid", 16'h0000, 0);
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_gaps();
        test_back_to_back();
        test_sof_abort();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
